// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants, FSM encoding and address decode for the register-bank write arbiter.
package reg_write_arbiter_pkg;

   localparam int NREQ       = 4;
   localparam int NREG       = 8;
   localparam int IDX_W      = 2;
   localparam int ADDR_W     = 3;
   localparam int LOCK_MAX   = 16;
   localparam int LOCK_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [NREG-1:0] decode_addr(input logic [ADDR_W-1:0] addr);
      logic [NREG-1:0] onehot;
      onehot       = '0;
      onehot[addr] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1, wrapping, ptr itself last.
module rr_pick
   import reg_write_arbiter_pkg::*;
(
   input  logic [NREQ-1:0]  req_masked,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] winner
);

   logic [IDX_W-1:0] cand;

   // Walk offsets from lowest to highest priority so the nearest candidate is written last.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = ptr + IDX_W'(k);
         if (req_masked[cand]) begin
            valid  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter with lockable back-to-back grants, driving an external register bank.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREQ  = reg_write_arbiter_pkg::NREQ,
   parameter int NREG  = reg_write_arbiter_pkg::NREG
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   input  logic [NREQ*ADDR_W-1:0]  waddr,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [NREG-1:0]         reg_en,
   output logic [WIDTH-1:0]        reg_d,
   output logic [IDX_W-1:0]        owner,
   output logic                    locked
);

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      ptr, ptr_nxt, owner_nxt;
   logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
   logic [NREQ-1:0]       gnt_nxt, mask, req_masked;
   logic [NREG-1:0]       reg_en_nxt;
   logic [WIDTH-1:0]      reg_d_nxt;
   logic                  pick_valid, hold, grant_any;
   logic [IDX_W-1:0]      pick_idx, grant_idx;

   // The owner is either the requester granted this cycle or the one leaving a lock.
   assign mask       = (state != IDLE) ? (NREQ'(1) << owner) : '0;
   assign req_masked = req & ~mask;
   assign hold       = (state == LOCKED) && req[owner] && lock[owner] &&
                       (lock_cnt < LOCK_CNT_W'(LOCK_MAX));

   rr_pick u_rr_pick (
      .req_masked (req_masked),
      .ptr        (ptr),
      .valid      (pick_valid),
      .winner     (pick_idx)
   );

   always_comb begin
      state_nxt    = IDLE;
      ptr_nxt      = ptr;
      owner_nxt    = owner;
      lock_cnt_nxt = '0;
      gnt_nxt      = '0;
      reg_en_nxt   = '0;
      reg_d_nxt    = '0;
      grant_any    = 1'b0;
      grant_idx    = owner;
      if (hold) begin
         grant_any    = 1'b1;
         state_nxt    = LOCKED;
         lock_cnt_nxt = lock_cnt + LOCK_CNT_W'(1);
      end else if (pick_valid) begin
         grant_any = 1'b1;
         grant_idx = pick_idx;
         if (lock[pick_idx]) begin
            state_nxt    = LOCKED;
            lock_cnt_nxt = LOCK_CNT_W'(1);
         end else begin
            state_nxt = GRANT;
         end
      end
      if (grant_any) begin
         gnt_nxt[grant_idx] = 1'b1;
         reg_en_nxt         = decode_addr(waddr[ADDR_W*grant_idx +: ADDR_W]);
         reg_d_nxt          = wdata[WIDTH*grant_idx +: WIDTH];
         ptr_nxt            = grant_idx;
         owner_nxt          = grant_idx;
      end
   end

   // ptr resets to the last index so requester 0 wins the first arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= IDX_W'(NREQ - 1);
         owner    <= '0;
         lock_cnt <= '0;
         gnt      <= '0;
         reg_en   <= '0;
         reg_d    <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         lock_cnt <= lock_cnt_nxt;
         gnt      <= gnt_nxt;
         reg_en   <= reg_en_nxt;
         reg_d    <= reg_d_nxt;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized checks of reg_write_arbiter against a cycle-level behavioural model.
module tb_reg_write_arbiter;

   localparam int WIDTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req, lock;
   logic [11:0]   waddr;
   logic [63:0]   wdata;
   logic [3:0]    gnt;
   logic [7:0]    reg_en;
   logic [15:0]   reg_d;
   logic [1:0]    owner;
   logic          locked;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: last pointer, current owner, requester excluded next time, lock run length.
   int   m_ptr, m_owner, m_skip, m_cnt;
   bit   m_locked;
   logic [3:0]  exp_gnt;
   logic [7:0]  exp_en;
   logic [15:0] exp_d;
   logic [1:0]  exp_owner;
   logic        exp_locked;

   reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(4), .NREG(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .lock   (lock),
      .waddr  (waddr),
      .wdata  (wdata),
      .gnt    (gnt),
      .reg_en (reg_en),
      .reg_d  (reg_d),
      .owner  (owner),
      .locked (locked)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic modelReset();
      m_ptr = 3; m_owner = 0; m_skip = -1; m_cnt = 0; m_locked = 0;
      exp_gnt = '0; exp_en = '0; exp_d = '0; exp_owner = '0; exp_locked = 1'b0;
   endtask

   // One arbitration decision from the inputs seen at this edge.
   task automatic modelStep();
      int  win;
      bit  keep;
      win  = -1;
      keep = m_locked && req[m_owner] && lock[m_owner] && (m_cnt < 16);
      if (keep) begin
         win = m_owner;
         m_cnt++;
      end else begin
         for (int off = 1; off <= 4; off++) begin
            int cand;
            cand = (m_ptr + off) % 4;
            if (win < 0 && req[cand] && cand != m_skip) win = cand;
         end
         m_locked = (win >= 0) ? bit'(lock[win]) : 1'b0;
         m_cnt    = m_locked ? 1 : 0;
      end
      if (win >= 0) begin
         m_ptr = win; m_owner = win; m_skip = win;
         exp_gnt = 4'(1 << win);
         exp_en  = 8'(1 << waddr[3*win +: 3]);
         exp_d   = wdata[16*win +: 16];
      end else begin
         m_skip = -1;
         exp_gnt = '0; exp_en = '0; exp_d = '0;
      end
      exp_owner  = 2'(m_owner);
      exp_locked = m_locked;
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".gnt"},    32'(gnt),    32'(exp_gnt));
      checkVal({tag, ".reg_en"}, 32'(reg_en), 32'(exp_en));
      checkVal({tag, ".reg_d"},  32'(reg_d),  32'(exp_d));
      checkVal({tag, ".owner"},  32'(owner),  32'(exp_owner));
      checkVal({tag, ".locked"}, 32'(locked), 32'(exp_locked));
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input string tag);
      req  = r;
      lock = l;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   task automatic setPort(input int i, input logic [2:0] a, input logic [15:0] d);
      waddr[3*i +: 3]   = a;
      wdata[16*i +: 16] = d;
   endtask

   initial begin
      logic [3:0] rr_seq [5];
      rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst = 1'b1; req = '0; lock = '0; waddr = '0; wdata = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      rst = 1'b0;

      // Round-robin rotation with all requesters held.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b1111, 4'b0000, "rr");
         checkVal($sformatf("rr_seq%0d", k), 32'(gnt), 32'(rr_seq[k]));
      end
      applyStimulus(4'b0000, 4'b0000, "rr_drop");

      // Single write to register 5.
      setPort(2, 3'd5, 16'hBEEF);
      applyStimulus(4'b0100, 4'b0000, "single");
      checkVal("single_gnt", 32'(gnt),    32'h4);
      checkVal("single_en",  32'(reg_en), 32'h20);
      checkVal("single_d",   32'(reg_d),  32'hBEEF);
      applyStimulus(4'b0000, 4'b0000, "single_drop");
      checkVal("single_zero", {gnt, reg_en, reg_d}, 32'h0);

      // Lock held past the limit: 16 locked grants then forced release.
      applyStimulus(4'b0010, 4'b0010, "lock16");
      for (int k = 0; k < 15; k++) applyStimulus(4'b0011, 4'b0010, "lock16");
      checkVal("lock16_last_gnt", 32'(gnt), 32'h2);
      checkVal("lock16_last_lk",  32'(locked), 32'h1);
      applyStimulus(4'b0011, 4'b0010, "lock16_rel");
      checkVal("lock16_rel_gnt", 32'(gnt), 32'h1);
      checkVal("lock16_rel_lk",  32'(locked), 32'h0);
      applyStimulus(4'b0000, 4'b0000, "lock16_drop");

      // Lock dropped early while another requester waits.
      applyStimulus(4'b1000, 4'b1000, "lockdrop");
      applyStimulus(4'b1010, 4'b1000, "lockdrop");
      applyStimulus(4'b1010, 4'b1000, "lockdrop");
      checkVal("lockdrop_held", 32'(gnt), 32'h8);
      applyStimulus(4'b1010, 4'b0000, "lockdrop_rel");
      checkVal("lockdrop_gnt", 32'(gnt), 32'h2);
      checkVal("lockdrop_lk",  32'(locked), 32'h0);
      applyStimulus(4'b0000, 4'b0000, "lockdrop_idle");

      // Asynchronous reset in the middle of a locked grant.
      applyStimulus(4'b0100, 4'b0100, "areset_lock");
      applyStimulus(4'b0100, 4'b0100, "areset_lock");
      req = 4'b0110;
      #3 rst = 1'b1;
      modelReset();
      #1;
      checkVal("areset_gnt",    32'(gnt),    32'h0);
      checkVal("areset_en",     32'(reg_en), 32'h0);
      checkVal("areset_locked", 32'(locked), 32'h0);
      checkOutput("areset");
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("areset_hold");
      applyStimulus(4'b0110, 4'b0000, "areset_first");
      checkVal("areset_first_gnt", 32'(gnt), 32'h2);
      applyStimulus(4'b0000, 4'b0000, "areset_idle");

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         waddr = 12'($urandom);
         wdata = {$urandom, $urandom};
         applyStimulus(4'($urandom), 4'($urandom & $urandom), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
